cache_fill_fsm: RTL and testbench



---
 rtl/cache_fill_fsm.sv | 124 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss refill controller.
//
// On a miss it stalls the pipeline, reads one 16-byte block from main memory
// as eight 16-bit words, writes each returned word into the cache data array,
// and writes the tag along with the final word.
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   miss_detected        - cache lookup missed this cycle (sampled in IDLE only)
//   miss_address         - byte address of the missing access
//   memory_data_valid    - memory_data carries a returned word this cycle
//   memory_data          - read data from main memory
//   fsm_busy             - refill in progress (pipeline stall)
//   mem_req              - one-word read request to main memory
//   memory_address       - byte address of the current request
//   write_data_array     - data array write enable
//   data_array_word      - word offset within the block being written
//   fill_data            - data to write into the data array
//   write_tag_array      - tag/valid array write enable
//   fill_base_address    - block-aligned address of the fill
module cache_fill_fsm #(
  parameter int unsigned WORDS   = 8,
  parameter int          MEM_LAT = 4  // informational; the FSM does not depend on it
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_req,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  data_array_word,
  output logic [15:0] fill_data,
  output logic        write_tag_array,
  output logic [15:0] fill_base_address
);

  // The counters are 3 bits wide and rely on wrapping at 8.
  if (WORDS != 8 || MEM_LAT < 0) begin : g_param_check
    $error("cache_fill_fsm: WORDS must be 8 and MEM_LAT non-negative");
  end

  localparam logic [2:0] LastWord = 3'(WORDS - 1);

  typedef enum logic {StIdle, StFill} state_e;

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic        issue_done_q, issue_done_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      recv_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      issue_done_q <= issue_done_d;
      recv_cnt_q   <= recv_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    issue_done_d = issue_done_q;
    recv_cnt_d   = recv_cnt_q;
    case (state_q)
      StIdle: begin
        // Returns arriving in IDLE are strays and are deliberately ignored.
        if (miss_detected) begin
          state_d      = StFill;
          base_d       = miss_address & 16'hFFF0;
          issue_cnt_d  = '0;
          issue_done_d = 1'b0;
          recv_cnt_d   = '0;
        end
      end
      StFill: begin
        if (!issue_done_q) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == LastWord) begin
            issue_done_d = 1'b1;
          end
        end
        // Returns are counted independently of issue, so a same-cycle
        // (zero-latency) return is still accepted.
        if (memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 3'd1;
          if (recv_cnt_q == LastWord) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    fsm_busy          = (state_q == StFill);
    mem_req           = (state_q == StFill) && !issue_done_q;
    // base_q is block aligned, so adding at most 14 never carries out of the block.
    memory_address    = mem_req ? (base_q + {12'b0, issue_cnt_q, 1'b0}) : 16'h0000;
    write_data_array  = (state_q == StFill) && memory_data_valid;
    data_array_word   = recv_cnt_q;
    fill_data         = memory_data;
    write_tag_array   = write_data_array && (recv_cnt_q == LastWord);
    fill_base_address = base_q;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a cycle-level model of the refill
// (fill start cycle, received-word count, latched block base) checked every
// cycle, plus hand-computed literal expectations per directed scenario.
module tb_cache_fill_fsm;

  logic        clk = 1'b1;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_base_address;

  cache_fill_fsm #(.WORDS(8), .MEM_LAT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_word   (data_array_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_base_address (fill_base_address)
  );

  // Cycle c spans posedge c to posedge c+1; the negedge sits mid-cycle.
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: a fill starts the cycle after an IDLE miss, requests
  // occupy the first 8 fill cycles, and the fill ends with the 8th return.
  logic        armed   = 1'b0;
  logic        m_busy  = 1'b0;
  int          m_start = 0;
  logic [15:0] m_base  = '0;
  int          m_nrecv = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      armed   <= 1'b1;
      m_busy  <= 1'b0;
      m_base  <= '0;
      m_nrecv <= 0;
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_busy  <= 1'b1;
        m_base  <= miss_address & 16'hFFF0;
        m_start <= cyc + 1;
        m_nrecv <= 0;
      end
    end else if (memory_data_valid) begin
      if (m_nrecv == 7) m_busy <= 1'b0;
      else              m_nrecv <= m_nrecv + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      int   k;
      logic exp_req;
      logic exp_wr;
      k       = cyc - m_start;
      exp_req = m_busy && (k >= 0) && (k < 8);
      exp_wr  = m_busy && memory_data_valid;
      chk("fsm_busy", 32'(fsm_busy), 32'(m_busy));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) chk("memory_address", 32'(memory_address), 32'(m_base + 16'(2 * k)));
      chk("write_data_array", 32'(write_data_array), 32'(exp_wr));
      if (exp_wr) chk("data_array_word", 32'(data_array_word), 32'(m_nrecv));
      chk("write_tag_array", 32'(write_tag_array), 32'(exp_wr && (m_nrecv == 7)));
      chk("fill_base_address", 32'(fill_base_address), 32'(m_base));
      chk("fill_data", 32'(fill_data), 32'(memory_data));
    end
  end

  // Directed stimulus, per scenario and scenario-relative cycle t.
  task automatic drive(input int tid, input int t, inout int vcount);
    logic r, m, v;
    logic [15:0] a;
    r = 1'b0; m = 1'b0; v = 1'b0; a = 16'h0000;
    case (tid)
      0: r = (t < 2);
      1: begin m = (t == 0); a = 16'h1236; v = (t >= 5 && t <= 12); end
      2: begin m = (t == 0); a = 16'h2008; v = t inside {5, 7, 8, 11, 12, 13, 15, 20}; end
      3: begin
        m = (t >= 2 && t <= 16);
        a = (t < 5) ? 16'h3456 : 16'h4568;
        v = t inside {0, 1, [7:14], [20:28]};
      end
      4: begin
        r = (t == 6);
        m = (t == 0 || t == 10);
        a = (t < 10) ? 16'h5550 : 16'h6660;
        v = t inside {[5:9], [15:22]};
      end
      5: begin m = (t == 0); a = 16'hFFFF; v = (t >= 1 && t <= 8); end
      default: ;
    endcase
    rst               = r;
    miss_detected     = m;
    miss_address      = a;
    memory_data_valid = v;
    if (v) begin
      memory_data = 16'hA000 + 16'(vcount);
      vcount++;
    end else begin
      memory_data = 16'h5A5A ^ 16'(t);
    end
  endtask

  // Hand-computed expectations sampled mid-cycle.
  task automatic literals(input int tid, input int t);
    case (tid)
      0: if (t == 1) begin
        chk("rst_busy", 32'(fsm_busy), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(memory_address), 0);
        chk("rst_wr", 32'(write_data_array), 0);
        chk("rst_tag", 32'(write_tag_array), 0);
        chk("rst_word", 32'(data_array_word), 0);
        chk("rst_base", 32'(fill_base_address), 0);
        chk("rst_fill_data", 32'(fill_data), 32'h5A5B);
      end
      1: case (t)
        1:  begin chk("basic_req1", 32'(mem_req), 1); chk("basic_addr1", 32'(memory_address), 32'h1230); end
        5:  begin
          chk("basic_wr5", 32'(write_data_array), 1);
          chk("basic_word5", 32'(data_array_word), 0);
          chk("basic_data5", 32'(fill_data), 32'hA000);
        end
        8:  chk("basic_addr8", 32'(memory_address), 32'h123E);
        9:  chk("basic_req9", 32'(mem_req), 0);
        11: chk("basic_tag11", 32'(write_tag_array), 0);
        12: begin
          chk("basic_tag12", 32'(write_tag_array), 1);
          chk("basic_word12", 32'(data_array_word), 7);
          chk("basic_data12", 32'(fill_data), 32'hA007);
          chk("basic_base12", 32'(fill_base_address), 32'h1230);
        end
        13: chk("basic_busy13", 32'(fsm_busy), 0);
        default: ;
      endcase
      2: case (t)
        7:  chk("gap_word7", 32'(data_array_word), 1);
        14: chk("gap_wr14", 32'(write_data_array), 0);
        15: chk("gap_word15", 32'(data_array_word), 6);
        19: chk("gap_busy19", 32'(fsm_busy), 1);
        20: begin chk("gap_tag20", 32'(write_tag_array), 1); chk("gap_word20", 32'(data_array_word), 7); end
        21: chk("gap_busy21", 32'(fsm_busy), 0);
        default: ;
      endcase
      3: case (t)
        0:  chk("stray_wr0", 32'(write_data_array), 0);
        1:  chk("stray_wr1", 32'(write_data_array), 0);
        3:  chk("held_addr3", 32'(memory_address), 32'h3450);
        10: chk("held_addr10", 32'(memory_address), 32'h345E);
        15: chk("held_busy15", 32'(fsm_busy), 0);
        16: begin
          chk("held_busy16", 32'(fsm_busy), 1);
          chk("held_base16", 32'(fill_base_address), 32'h4560);
          chk("held_addr16", 32'(memory_address), 32'h4560);
        end
        27: chk("held_tag27", 32'(write_tag_array), 1);
        28: chk("excess_wr28", 32'(write_data_array), 0);
        default: ;
      endcase
      4: case (t)
        6:  begin chk("rstmid_wr6", 32'(write_data_array), 1); chk("rstmid_word6", 32'(data_array_word), 1); end
        7:  begin
          chk("rstmid_busy7", 32'(fsm_busy), 0);
          chk("rstmid_wr7", 32'(write_data_array), 0);
          chk("rstmid_req7", 32'(mem_req), 0);
          chk("rstmid_base7", 32'(fill_base_address), 0);
        end
        8:  chk("rstmid_wr8", 32'(write_data_array), 0);
        11: begin chk("rstmid_busy11", 32'(fsm_busy), 1); chk("rstmid_addr11", 32'(memory_address), 32'h6660); end
        15: begin chk("rstmid_wr15", 32'(write_data_array), 1); chk("rstmid_word15", 32'(data_array_word), 0); end
        22: begin chk("rstmid_tag22", 32'(write_tag_array), 1); chk("rstmid_base22", 32'(fill_base_address), 32'h6660); end
        default: ;
      endcase
      5: case (t)
        1: begin
          chk("top_base1", 32'(fill_base_address), 32'hFFF0);
          chk("top_addr1", 32'(memory_address), 32'hFFF0);
          chk("top_wr1", 32'(write_data_array), 1);
          chk("top_word1", 32'(data_array_word), 0);
        end
        8: begin
          chk("top_addr8", 32'(memory_address), 32'hFFFE);
          chk("top_tag8", 32'(write_tag_array), 1);
          chk("top_word8", 32'(data_array_word), 7);
        end
        9: begin chk("top_busy9", 32'(fsm_busy), 0); chk("top_req9", 32'(mem_req), 0); end
        default: ;
      endcase
      default: ;
    endcase
  endtask

  initial begin
    int lens [6] = '{3, 15, 23, 30, 25, 11};
    for (int tid = 0; tid < 6; tid++) begin
      int vcount;
      vcount = 0;
      for (int t = 0; t < lens[tid]; t++) begin
        drive(tid, t, vcount);
        @(negedge clk);
        literals(tid, t);
        @(posedge clk);
        #1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
